serial_to_parallel_register: RTL and testbench

//  Receive end of the team's parallel-load register path. Shifts in a serial
//  bit stream LSB-first and assembles it into a WIDTH-bit word. After a full

---
 rtl/serial_to_parallel_register.sv | 103 ++++++++++
 tb/tb_serial_to_parallel_register.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_register.sv
// LSB-first serial-to-parallel receiver: assembles WIDTH-bit frames into Q with a one-cycle Ready strobe.
// Optional even-parity trailer bit enabled by defining SERIAL_PARITY_CHECK_EN.
module serial_to_parallel_register #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SIn,
  input  logic             SValid,
  input  logic             Sync,
  output logic [WIDTH-1:0] Q,
  output logic             Ready,
  output logic             Busy,
  output logic             ParErr
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             last_bit;

  // Incoming bit lands at the position given by the running count.
  always_comb begin
    sreg_nxt = sreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) sreg_nxt[i] = SIn;
    end
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign Busy     = (state != IDLE);

`ifdef SERIAL_PARITY_CHECK_EN
  logic parerr_r;
  assign ParErr = parerr_r;
`else
  assign ParErr = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      Q     <= '0;
      Ready <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      parerr_r <= 1'b0;
`endif
    end else begin
      Ready <= 1'b0;
      if (Sync) begin
        // Restart wins over any bit presented on the same edge.
        state <= IDLE;
        cnt   <= '0;
      end else if (SValid) begin
        case (state)
          IDLE, SHIFT: begin
            if (last_bit) begin
`ifdef SERIAL_PARITY_CHECK_EN
              sreg  <= sreg_nxt;
              cnt   <= CW'(WIDTH);
              state <= PAR;
`else
              Q     <= sreg_nxt;
              Ready <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
`endif
            end else begin
              sreg  <= sreg_nxt;
              cnt   <= cnt + CW'(1);
              state <= SHIFT;
            end
          end
`ifdef SERIAL_PARITY_CHECK_EN
          PAR: begin
            Q        <= sreg;
            Ready    <= 1'b1;
            parerr_r <= ^{sreg, SIn};
            cnt      <= '0;
            state    <= IDLE;
          end
`endif
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_register.sv
// Bench for serial_to_parallel_register: vector table, hand-built corner sequences, and random traffic
// checked against a queue-based frame model.
module tb_serial_to_parallel_register;

  localparam int WIDTH = 4;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             SIn;
  logic             SValid;
  logic             Sync;
  logic [WIDTH-1:0] Q;
  logic             Ready;
  logic             Busy;
  logic             ParErr;

  serial_to_parallel_register #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RSTn(RSTn), .SIn(SIn), .SValid(SValid), .Sync(Sync),
    .Q(Q), .Ready(Ready), .Busy(Busy), .ParErr(ParErr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bits of the frame in flight, plus the last delivered results.
  bit               mq[$];
  logic [WIDTH-1:0] m_q;
  logic             m_rdy;
  logic             m_perr;

  typedef struct {
    logic             sin;
    logic             svalid;
    logic             sync;
    logic [WIDTH-1:0] eq;
    logic             erdy;
    logic             ebusy;
    logic             eperr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_q    = '0;
    m_rdy  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic y);
    logic [WIDTH-1:0] w;
    logic             p;
    m_rdy = 1'b0;
    if (y) begin
      mq.delete();
    end else if (v) begin
      mq.push_back(s);
      if (mq.size() == FRAME) begin
        w = '0;
        p = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i < WIDTH) w[i] = mq[i];
          p = p ^ mq[i];
        end
        m_q   = w;
        m_rdy = 1'b1;
`ifdef SERIAL_PARITY_CHECK_EN
        m_perr = p;
`endif
        mq.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".Q"},      32'(Q),      32'(m_q));
    chk({tag, ".Ready"},  32'(Ready),  32'(m_rdy));
    chk({tag, ".Busy"},   32'(Busy),   32'(mq.size() != 0));
    chk({tag, ".ParErr"}, 32'(ParErr), 32'(m_perr));
  endtask

  task automatic drive(input logic s, input logic v, input logic y, input string tag);
    SIn    = s;
    SValid = v;
    Sync   = y;
    @(posedge CLK);
    model_edge(s, v, y);
    #1;
    check_model(tag);
  endtask

  task automatic addv(input logic s, input logic v, input logic y, input logic [WIDTH-1:0] q,
                      input logic r, input logic b, input logic pe);
    vec_t e;
    e.sin = s; e.svalid = v; e.sync = y; e.eq = q; e.erdy = r; e.ebusy = b; e.eperr = pe;
    tbl.push_back(e);
  endtask

  initial begin
    logic       s, v, y;
    logic [4:0] gb;

    RSTn = 1'b0; SIn = 1'b0; SValid = 1'b0; Sync = 1'b0;
    model_reset();
    #19;
    chk("rst.Q", 32'(Q), 32'h0);
    chk("rst.Ready", 32'(Ready), 32'h0);
    chk("rst.Busy", 32'(Busy), 32'h0);
    chk("rst.ParErr", 32'(ParErr), 32'h0);
    #1 RSTn = 1'b1;
    @(posedge CLK);
    #1;

`ifndef SERIAL_PARITY_CHECK_EN
    // basic frame 0,1,1,0
    addv(0,1,0, 4'h0,0,1,0); addv(1,1,0, 4'h0,0,1,0); addv(1,1,0, 4'h0,0,1,0);
    addv(0,1,0, 4'h6,1,0,0); addv(0,0,0, 4'h6,0,0,0);
    // back-to-back 1,0,1,0 then 1,1,1,1
    addv(1,1,0, 4'h6,0,1,0); addv(0,1,0, 4'h6,0,1,0); addv(1,1,0, 4'h6,0,1,0);
    addv(0,1,0, 4'h5,1,0,0); addv(1,1,0, 4'h5,0,1,0); addv(1,1,0, 4'h5,0,1,0);
    addv(1,1,0, 4'h5,0,1,0); addv(1,1,0, 4'hF,1,0,0); addv(0,0,0, 4'hF,0,0,0);
    // two bits, Sync (with a discarded bit), then 1,0,0,1
    addv(1,1,0, 4'hF,0,1,0); addv(1,1,0, 4'hF,0,1,0); addv(1,1,1, 4'hF,0,0,0);
    addv(1,1,0, 4'hF,0,1,0); addv(0,1,0, 4'hF,0,1,0); addv(0,1,0, 4'hF,0,1,0);
    addv(1,1,0, 4'h9,1,0,0); addv(0,0,0, 4'h9,0,0,0);
    // Sync on the final-bit edge suppresses completion
    addv(0,1,0, 4'h9,0,1,0); addv(0,1,0, 4'h9,0,1,0); addv(0,1,0, 4'h9,0,1,0);
    addv(1,1,1, 4'h9,0,0,0); addv(0,0,0, 4'h9,0,0,0);
`else
    // data 1,1,0,0 with parity 1, then with parity 0, then Sync during the parity slot
    addv(1,1,0, 4'h0,0,1,0); addv(1,1,0, 4'h0,0,1,0); addv(0,1,0, 4'h0,0,1,0);
    addv(0,1,0, 4'h0,0,1,0); addv(1,1,0, 4'h3,1,0,1); addv(0,0,0, 4'h3,0,0,1);
    addv(1,1,0, 4'h3,0,1,1); addv(1,1,0, 4'h3,0,1,1); addv(0,1,0, 4'h3,0,1,1);
    addv(0,1,0, 4'h3,0,1,1); addv(0,1,0, 4'h3,1,0,0); addv(0,0,0, 4'h3,0,0,0);
    addv(1,1,0, 4'h3,0,1,0); addv(1,1,0, 4'h3,0,1,0); addv(1,1,0, 4'h3,0,1,0);
    addv(1,1,0, 4'h3,0,1,0); addv(0,0,0, 4'h3,0,1,0); addv(1,1,1, 4'h3,0,0,0);
    addv(0,0,0, 4'h3,0,0,0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sin, tbl[i].svalid, tbl[i].sync, "tbl.model");
      chk("tbl.Q",      32'(Q),      32'(tbl[i].eq));
      chk("tbl.Ready",  32'(Ready),  32'(tbl[i].erdy));
      chk("tbl.Busy",   32'(Busy),   32'(tbl[i].ebusy));
      chk("tbl.ParErr", 32'(ParErr), 32'(tbl[i].eperr));
    end

    // Gapped frame: bits 0,1,1,0 (parity 0), three idle cycles between bits.
    gb = 5'b00110;
    for (int i = 0; i < FRAME; i++) begin
      drive(gb[i], 1'b1, 1'b0, "gap");
      if (i < FRAME - 1) begin
        for (int k = 0; k < 3; k++) begin
          drive(1'b0, 1'b0, 1'b0, "gap.idle");
          chk("gap.Busy", 32'(Busy), 32'h1);
        end
      end
    end
    chk("gap.Q", 32'(Q), 32'h6);
    chk("gap.Ready", 32'(Ready), 32'h1);

    // Async reset while Ready is high and Q is non-zero.
    SValid = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    model_reset();
    check_model("arst1");
    @(negedge CLK);
    RSTn = 1'b1;

    // Async reset in the middle of a partial frame.
    drive(1'b1, 1'b1, 1'b0, "part");
    drive(1'b1, 1'b1, 1'b0, "part");
    SValid = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    model_reset();
    check_model("arst2");
    chk("arst2.Busy", 32'(Busy), 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      s = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 9) < 6);
      y = ($urandom_range(0, 19) == 0);
      drive(s, v, y, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
